sv32_ptw: RTL and testbench

- Hardware Sv32 page table walker. Responder side of the TLB-miss interface; the ITLB and DTLB are the initiators.
- Accepts one miss (VPN, ASID, root PPN) at a time and reads up to two 4B PTEs through a single-outstanding memory read port.
- Returns the leaf PTE in Sv32 PTE layout with a superpage flag, or a page fault.
- Sits between the TLBs and the L2/dcache PTE read path.

---
 rtl/sv32_ptw.sv | 173 +++++++++++++++++
 tb/tb_sv32_ptw.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw.sv
// Sv32 hardware page table walker: one TLB miss at a time, up to two PTE reads, single outstanding read.
// Optional one-entry level-1 PTE cache enabled by defining SV32_PTW_L1_PTE_CACHE_EN.
module sv32_ptw #(
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 22,
    parameter int PA_WIDTH   = 34,
    parameter int ASID_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VPN_WIDTH-1:0]  req_VPN,
    input  logic [ASID_WIDTH-1:0] req_ASID,
    input  logic [PPN_WIDTH-1:0]  req_satp_PPN,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [PA_WIDTH-1:0]   mem_req_PA,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_pte,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [VPN_WIDTH-1:0]  resp_VPN,
    output logic [ASID_WIDTH-1:0] resp_ASID,
    output logic [31:0]           resp_pte,
    output logic                  resp_superpage,
    output logic                  resp_page_fault,
    input  logic                  flush
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [VPN_WIDTH-1:0]    vpn_q, vpn_d;
    logic [ASID_WIDTH-1:0]   asid_q, asid_d;
    logic [PPN_WIDTH-1:0]    satp_q, satp_d;
    logic [PPN_WIDTH-1:0]    ppn_q, ppn_d;
    logic [31:0]             pte_q, pte_d;
    logic                    super_q, super_d;
    logic                    fault_q, fault_d;

    // PTE field decode: V=0, R=1, W=2, X=3, A=6
    logic pte_leaf, pte_fault_common;
    assign pte_leaf         = mem_resp_pte[1] | mem_resp_pte[3];
    assign pte_fault_common = ~mem_resp_pte[0] | (~mem_resp_pte[1] & mem_resp_pte[2]) |
                              (pte_leaf & ~mem_resp_pte[6]);

`ifdef SV32_PTW_L1_PTE_CACHE_EN
    logic                      cache_vld_q, cache_vld_d;
    logic [PPN_WIDTH+9:0]      cache_tag_q, cache_tag_d;
    logic [PPN_WIDTH-1:0]      cache_ppn_q, cache_ppn_d;
    logic                      cache_hit;
    assign cache_hit = cache_vld_q && (cache_tag_q == {req_satp_PPN, req_VPN[19:10]});
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            vpn_q   <= '0;
            asid_q  <= '0;
            satp_q  <= '0;
            ppn_q   <= '0;
            pte_q   <= '0;
            super_q <= 1'b0;
            fault_q <= 1'b0;
`ifdef SV32_PTW_L1_PTE_CACHE_EN
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
            cache_ppn_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            asid_q  <= asid_d;
            satp_q  <= satp_d;
            ppn_q   <= ppn_d;
            pte_q   <= pte_d;
            super_q <= super_d;
            fault_q <= fault_d;
`ifdef SV32_PTW_L1_PTE_CACHE_EN
            cache_vld_q <= cache_vld_d;
            cache_tag_q <= cache_tag_d;
            cache_ppn_q <= cache_ppn_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        asid_d  = asid_q;
        satp_d  = satp_q;
        ppn_d   = ppn_q;
        pte_d   = pte_q;
        super_d = super_q;
        fault_d = fault_q;
`ifdef SV32_PTW_L1_PTE_CACHE_EN
        cache_vld_d = flush ? 1'b0 : cache_vld_q;
        cache_tag_d = cache_tag_q;
        cache_ppn_d = cache_ppn_q;
`endif
        unique case (state_q)
            IDLE: if (!flush && req_valid) begin
                vpn_d   = req_VPN;
                asid_d  = req_ASID;
                satp_d  = req_satp_PPN;
                state_d = L1_REQ;
`ifdef SV32_PTW_L1_PTE_CACHE_EN
                if (cache_hit) begin
                    ppn_d   = cache_ppn_q;
                    state_d = L0_REQ;
                end
`endif
            end
            L1_REQ: begin
                if (flush)              state_d = IDLE;
                else if (mem_req_ready) state_d = L1_WAIT;
            end
            L1_WAIT: begin
                // a response coinciding with flush is already consumed, so no drain needed
                if (flush)                state_d = mem_resp_valid ? IDLE : DRAIN;
                else if (mem_resp_valid) begin
                    if (pte_fault_common || (pte_leaf && mem_resp_pte[19:10] != 10'd0)) begin
                        pte_d = '0; super_d = 1'b0; fault_d = 1'b1; state_d = RESP;
                    end else if (pte_leaf) begin
                        pte_d = mem_resp_pte; super_d = 1'b1; fault_d = 1'b0; state_d = RESP;
                    end else begin
                        ppn_d   = mem_resp_pte[31:10];
                        state_d = L0_REQ;
`ifdef SV32_PTW_L1_PTE_CACHE_EN
                        cache_vld_d = 1'b1;
                        cache_tag_d = {satp_q, vpn_q[19:10]};
                        cache_ppn_d = mem_resp_pte[31:10];
`endif
                    end
                end
            end
            L0_REQ: begin
                if (flush)              state_d = IDLE;
                else if (mem_req_ready) state_d = L0_WAIT;
            end
            L0_WAIT: begin
                if (flush)                state_d = mem_resp_valid ? IDLE : DRAIN;
                else if (mem_resp_valid) begin
                    state_d = RESP;
                    super_d = 1'b0;
                    if (pte_fault_common || !pte_leaf) begin
                        pte_d = '0; fault_d = 1'b1;
                    end else begin
                        pte_d = mem_resp_pte; fault_d = 1'b0;
                    end
                end
            end
            RESP:  if (flush || resp_ready) state_d = IDLE;
            DRAIN: if (mem_resp_valid)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_PA = '0;
        if (state_q == L1_REQ)      mem_req_PA = {satp_q, vpn_q[19:10], 2'b00};
        else if (state_q == L0_REQ) mem_req_PA = {ppn_q, vpn_q[9:0], 2'b00};
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_req_valid   = (state_q == L1_REQ) || (state_q == L0_REQ);
    assign resp_valid      = (state_q == RESP);
    assign resp_VPN        = vpn_q;
    assign resp_ASID       = asid_q;
    assign resp_pte        = pte_q;
    assign resp_superpage  = super_q;
    assign resp_page_fault = fault_q;
endmodule

// File: tb/tb_sv32_ptw.sv
// Directed self-checking bench for sv32_ptw; cache scenario runs when SV32_PTW_L1_PTE_CACHE_EN is defined.
module tb_sv32_ptw;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_VPN = '0;
    logic [8:0]  req_ASID = '0;
    logic [21:0] req_satp_PPN = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [33:0] mem_req_PA;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_pte = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [19:0] resp_VPN;
    logic [8:0]  resp_ASID;
    logic [31:0] resp_pte;
    logic        resp_superpage;
    logic        resp_page_fault;
    logic        flush = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int n_rd = 0;

    sv32_ptw dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_VPN(req_VPN),
        .req_ASID(req_ASID), .req_satp_PPN(req_satp_PPN),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_PA(mem_req_PA),
        .mem_resp_valid(mem_resp_valid), .mem_resp_pte(mem_resp_pte),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_VPN(resp_VPN),
        .resp_ASID(resp_ASID), .resp_pte(resp_pte), .resp_superpage(resp_superpage),
        .resp_page_fault(resp_page_fault), .flush(flush)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (mem_req_valid && mem_req_ready) n_rd <= n_rd + 1;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic issue(input logic [21:0] satp, input logic [19:0] vpn, input logic [8:0] asid);
        req_valid = 1'b1; req_satp_PPN = satp; req_VPN = vpn; req_ASID = asid;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_mreq(output logic [33:0] pa, output bit ok);
        ok = 1'b0; pa = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req_valid) begin ok = 1'b1; pa = mem_req_PA; end
            else tick();
        end
    endtask

    task automatic serve(input logic [31:0] pte);
        tick();
        mem_resp_valid = 1'b1; mem_resp_pte = pte;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (resp_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        n_chk++;
        if ({req_ready, mem_req_valid, mem_req_PA} !== {1'b1, 1'b0, 34'h0})
            $display("FAIL reset_mem: ready/valid/PA=%b/%b/%h want 1/0/0", req_ready, mem_req_valid, mem_req_PA);
        else n_pass++;
        n_chk++;
        if ({resp_valid, resp_VPN, resp_ASID, resp_pte, resp_superpage, resp_page_fault} !== 64'h0)
            $display("FAIL reset_resp: valid=%b vpn=%h asid=%h pte=%h sp=%b pf=%b want all 0",
                     resp_valid, resp_VPN, resp_ASID, resp_pte, resp_superpage, resp_page_fault);
        else n_pass++;
    endtask

    task automatic test_walk_4k();
        logic [33:0] pa; bit ok; int rd0;
        rd0 = n_rd;
        issue(22'h00123, 20'h12345, 9'h1A5);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h123120) $display("FAIL walk4k_l1_pa: got %h ok=%0d want 123120", pa, ok);
        else n_pass++;
        serve(32'h00115801);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h456D14) $display("FAIL walk4k_l0_pa: got %h ok=%0d want 456d14", pa, ok);
        else n_pass++;
        serve(32'h001E24C3);
        wait_resp(ok);
        n_chk++;
        if (!ok || {resp_pte, resp_superpage, resp_page_fault} !== {32'h001E24C3, 1'b0, 1'b0})
            $display("FAIL walk4k_resp: pte=%h sp=%b pf=%b ok=%0d want 1e24c3/0/0", resp_pte, resp_superpage, resp_page_fault, ok);
        else n_pass++;
        n_chk++;
        if ({resp_VPN, resp_ASID} !== {20'h12345, 9'h1A5})
            $display("FAIL walk4k_echo: vpn=%h asid=%h want 12345/1a5", resp_VPN, resp_ASID);
        else n_pass++;
        take_resp();
        n_chk++;
        if (n_rd - rd0 !== 2 || req_ready !== 1'b1)
            $display("FAIL walk4k_reads: reads=%0d ready=%b want 2/1", n_rd - rd0, req_ready);
        else n_pass++;
    endtask

    task automatic test_superpage();
        logic [33:0] pa; bit ok; int rd0;
        rd0 = n_rd;
        issue(22'h00210, 20'h12345, 9'h007);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h210120) $display("FAIL super_l1_pa: got %h ok=%0d want 210120", pa, ok);
        else n_pass++;
        serve(32'h0050004B);
        wait_resp(ok);
        n_chk++;
        if (!ok || {resp_pte, resp_superpage, resp_page_fault} !== {32'h0050004B, 1'b1, 1'b0})
            $display("FAIL super_resp: pte=%h sp=%b pf=%b ok=%0d want 50004b/1/0", resp_pte, resp_superpage, resp_page_fault, ok);
        else n_pass++;
        take_resp();
        n_chk++;
        if (n_rd - rd0 !== 1) $display("FAIL super_reads: got %0d want 1", n_rd - rd0);
        else n_pass++;
    endtask

    task automatic test_faults();
        logic [31:0] l1_pte [4] = '{32'h0050044B, 32'h00000000, 32'h00115801, 32'h00115801};
        logic [31:0] l0_pte [4] = '{32'h0, 32'h0, 32'h001E2483, 32'h00115801};
        bit          two    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [33:0] pa; bit ok;
        for (int i = 0; i < 4; i++) begin
            issue(22'h00200 + 22'(i), 20'h12345, 9'h0);
            wait_mreq(pa, ok);
            serve(l1_pte[i]);
            if (two[i]) begin
                wait_mreq(pa, ok);
                serve(l0_pte[i]);
            end
            wait_resp(ok);
            n_chk++;
            if (!ok || {resp_page_fault, resp_superpage, resp_pte} !== {1'b1, 1'b0, 32'h0})
                $display("FAIL fault_case%0d: pf=%b sp=%b pte=%h ok=%0d want 1/0/0", i, resp_page_fault, resp_superpage, resp_pte, ok);
            else n_pass++;
            take_resp();
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] pa; bit ok; int bad;
        mem_req_ready = 1'b0;
        issue(22'h00300, 20'h12345, 9'h055);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!mem_req_valid || mem_req_PA !== 34'h300120) bad++;
            tick();
        end
        n_chk++;
        if (bad !== 0 || mem_req_PA !== 34'h300120)
            $display("FAIL bp_mem_stable: unstable cycles=%0d PA=%h want 0/300120", bad, mem_req_PA);
        else n_pass++;
        mem_req_ready = 1'b1;
        serve(32'h00115801);
        wait_mreq(pa, ok);
        serve(32'h001E24C3);
        wait_resp(ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 4; i++) begin
            if ({resp_valid, req_ready, resp_pte, resp_ASID, resp_page_fault} !==
                {1'b1, 1'b0, 32'h001E24C3, 9'h055, 1'b0}) bad++;
            tick();
        end
        n_chk++;
        if (bad !== 0 || resp_valid !== 1'b1)
            $display("FAIL bp_resp_stable: bad cycles=%0d valid=%b want 0/1", bad, resp_valid);
        else n_pass++;
        take_resp();
        n_chk++;
        if ({resp_valid, req_ready} !== 2'b01) $display("FAIL bp_release: valid/ready=%b%b want 01", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_flush_drain();
        logic [33:0] pa; bit ok; int seen, busy;
        issue(22'h00400, 20'h12345, 9'h033);
        wait_mreq(pa, ok);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0; busy = 0;
        for (int i = 0; i < 2; i++) begin
            if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) busy++;
            if (resp_valid) seen++;
            tick();
        end
        mem_resp_valid = 1'b1; mem_resp_pte = 32'h0050004B;
        tick();
        mem_resp_valid = 1'b0;
        n_chk++;
        if (busy !== 0) $display("FAIL flush_drain_busy: idle-looking cycles=%0d want 0", busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        n_chk++;
        if (seen !== 0 || req_ready !== 1'b1)
            $display("FAIL flush_discard: resp_valid cycles=%0d ready=%b want 0/1", seen, req_ready);
        else n_pass++;
        issue(22'h00400, 20'h12345, 9'h033);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h400120) $display("FAIL flush_after_l1: got %h ok=%0d want 400120", pa, ok);
        else n_pass++;
        serve(32'h00115801);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h456D14) $display("FAIL flush_after_l0: got %h ok=%0d want 456d14", pa, ok);
        else n_pass++;
        serve(32'h001E24C3);
        wait_resp(ok);
        n_chk++;
        if (!ok || {resp_pte, resp_ASID, resp_page_fault} !== {32'h001E24C3, 9'h033, 1'b0})
            $display("FAIL flush_after_resp: pte=%h asid=%h pf=%b want 1e24c3/033/0", resp_pte, resp_ASID, resp_page_fault);
        else n_pass++;
        take_resp();
    endtask

    task automatic test_flush_idle_req();
        flush = 1'b1; req_valid = 1'b1; req_satp_PPN = 22'h00123; req_VPN = 20'h12345;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        n_chk++;
        if ({req_ready, mem_req_valid} !== 2'b10)
            $display("FAIL flush_wins: ready/mreq=%b%b want 10", req_ready, mem_req_valid);
        else n_pass++;
    endtask

`ifdef SV32_PTW_L1_PTE_CACHE_EN
    task automatic test_l1_cache();
        logic [33:0] pa; bit ok; int rd0;
        issue(22'h00123, 20'h12345, 9'h001);
        wait_mreq(pa, ok); serve(32'h00115801);
        wait_mreq(pa, ok); serve(32'h001E24C3);
        wait_resp(ok); take_resp();
        rd0 = n_rd;
        issue(22'h00123, 20'h12346, 9'h001);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h456D18 || n_rd !== rd0)
            $display("FAIL cache_hit_pa: got %h reads=%0d ok=%0d want 456d18/0", pa, n_rd - rd0, ok);
        else n_pass++;
        serve(32'h001E24C3);
        wait_resp(ok);
        n_chk++;
        if (!ok || {resp_pte, resp_superpage, resp_page_fault} !== {32'h001E24C3, 1'b0, 1'b0})
            $display("FAIL cache_hit_resp: pte=%h sp=%b pf=%b want 1e24c3/0/0", resp_pte, resp_superpage, resp_page_fault);
        else n_pass++;
        take_resp();
        flush = 1'b1; tick(); flush = 1'b0;
        issue(22'h00123, 20'h12346, 9'h001);
        wait_mreq(pa, ok);
        n_chk++;
        if (!ok || pa !== 34'h123120) $display("FAIL cache_flushed_pa: got %h ok=%0d want 123120", pa, ok);
        else n_pass++;
        serve(32'h00115801);
        wait_mreq(pa, ok); serve(32'h001E24C3);
        wait_resp(ok); take_resp();
    endtask
`endif

    initial begin
        test_reset();
        test_walk_4k();
        test_superpage();
        test_faults();
        test_backpressure();
        test_flush_drain();
        test_flush_idle_req();
`ifdef SV32_PTW_L1_PTE_CACHE_EN
        test_l1_cache();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
